// File: rtl/fft_frame_feeder_1024.sv
// fft_frame_feeder_1024
// Collects ADC samples into a two-bank ping-pong buffer and replays each
// complete frame to the FFT core as one contiguous N-cycle burst with an
// index, start and end marker. Frames that arrive while both banks hold
// unconsumed data are discarded and counted.
module fft_frame_feeder_1024 #(
   parameter int N  = 1024,
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] adc_data,
   input  logic          adc_valid,
   input  logic          fft_rdy,
   output logic [31:0]   f_in,
   output logic          ipd_i,
   output logic [AW-1:0] idx_i,
   output logic          sof,
   output logic          eof,
   output logic          frame_drop,
   output logic [15:0]   drop_cnt
);

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_RDY, S_STREAM, S_GAP} state_t;

   // Both banks in one array; the bank select is the address MSB.
   logic [DW-1:0] mem [0:2*N-1];

   // Reader side
   state_t        state_q;
   logic          rd_bank_q;
   logic [AW-1:0] rd_addr_q;
   logic          gap_cnt_q;
   logic          p1_vld_q;
   logic [AW-1:0] p1_idx_q;
   logic [DW-1:0] p1_data_q;

   // Writer side
   logic          wr_bank_q, wr_bank_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [1:0]    full_q, full_d;
   logic          discard_q, discard_d;
   logic          drop_d;
   logic [15:0]   drop_cnt_d;

   logic          rd_issue;
   logic          release_w;
   logic [1:0]    full_rel;
   logic          discard_now;
   logic          wr_en;
   logic          frame_done;

   assign rd_issue  = (state_q == S_STREAM);
   // The streamed bank is handed back on the cycle its last sample leaves
   // the read pipeline, i.e. the same edge that raises eof.
   assign release_w = p1_vld_q && (p1_idx_q == LAST);

   // Full flags as the writer sees them: a release this cycle wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the block can leave it unassigned and infer a latch.
      full_rel = full_q;
      if (release_w) full_rel[rd_bank_q] = 1'b0;
   end

   // A frame is kept or discarded based on whether its bank is free when
   // its first sample arrives; a discarded frame never touches memory.
   assign discard_now = (wr_addr_q == '0) ? full_rel[wr_bank_q] : discard_q;
   assign wr_en       = adc_valid && !discard_now;
   assign frame_done  = adc_valid && (wr_addr_q == LAST);

   // Writer next state: address advance, bank hand-over or drop accounting.
   always_comb begin
      wr_addr_d  = wr_addr_q;
      wr_bank_d  = wr_bank_q;
      full_d     = full_rel;
      discard_d  = discard_q;
      drop_d     = 1'b0;
      drop_cnt_d = drop_cnt;
      if (adc_valid) begin
         wr_addr_d = wr_addr_q + 1'b1;
         discard_d = discard_now;
         if (frame_done) begin
            wr_addr_d = '0;
            discard_d = 1'b0;
            if (discard_now) begin
               drop_d = 1'b1;
               if (drop_cnt != 16'hFFFF) drop_cnt_d = drop_cnt + 16'd1;
            end else begin
               full_d[wr_bank_q] = 1'b1;
               wr_bank_d         = ~wr_bank_q;
            end
         end
      end
   end

   // Writer registers, bank full flags and drop reporting.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every register samples the values from before this edge.
      if (!rst) begin
         wr_addr_q  <= '0;
         wr_bank_q  <= 1'b0;
         full_q     <= 2'b00;
         discard_q  <= 1'b0;
         frame_drop <= 1'b0;
         drop_cnt   <= 16'h0000;
      end else begin
         wr_addr_q  <= wr_addr_d;
         wr_bank_q  <= wr_bank_d;
         full_q     <= full_d;
         discard_q  <= discard_d;
         frame_drop <= drop_d;
         drop_cnt   <= drop_cnt_d;
      end
   end

   // Sample memory: one write port for the ADC, one registered read port.
   always_ff @(posedge clk) begin
      // NOTE: the memory array is intentionally not reset; its contents are
      // never observed before being rewritten, and a reset would block RAM
      // inference.
      if (rst && wr_en) mem[{wr_bank_q, wr_addr_q}] <= adc_data;
      p1_data_q <= mem[{rd_bank_q, rd_addr_q}];
   end

   // Reader FSM: wait for a full bank and a ready core, stream, then gap.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         rd_bank_q <= 1'b0;
         rd_addr_q <= '0;
         gap_cnt_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (full_q[rd_bank_q]) state_q <= S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
               if (fft_rdy) begin
                  state_q   <= S_STREAM;
                  rd_addr_q <= '0;
               end
            end
            S_STREAM: begin
               if (rd_addr_q == LAST) begin
                  state_q   <= S_GAP;
                  gap_cnt_q <= 1'b0;
               end else begin
                  rd_addr_q <= rd_addr_q + 1'b1;
               end
            end
            S_GAP: begin
               gap_cnt_q <= 1'b1;
               if (gap_cnt_q) begin
                  rd_bank_q <= ~rd_bank_q;
                  state_q   <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Read pipeline tags and the registered FFT-side outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         p1_vld_q <= 1'b0;
         p1_idx_q <= '0;
         f_in     <= 32'h0;
         ipd_i    <= 1'b0;
         idx_i    <= '0;
         sof      <= 1'b0;
         eof      <= 1'b0;
      end else begin
         p1_vld_q <= rd_issue;
         p1_idx_q <= rd_addr_q;
         ipd_i    <= p1_vld_q;
         idx_i    <= p1_vld_q ? p1_idx_q : '0;
         f_in     <= p1_vld_q ? {p1_data_q, 16'h0000} : 32'h0;
         sof      <= p1_vld_q && (p1_idx_q == '0);
         eof      <= release_w;
      end
   end

endmodule

// File: tb/tb_fft_frame_feeder_1024.sv
// Bench for fft_frame_feeder_1024: a paced ADC driver feeds a frame-level
// reference model that queues expected bursts; an independent monitor pops
// and compares every FFT-side beat and every drop pulse.
module tb_fft_frame_feeder_1024;

   localparam int N  = 1024;
   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] adc_data;
   logic          adc_valid;
   logic          fft_rdy = 1'b0;
   logic [31:0]   f_in;
   logic          ipd_i;
   logic [AW-1:0] idx_i;
   logic          sof;
   logic          eof;
   logic          frame_drop;
   logic [15:0]   drop_cnt;

   always #5 clk = ~clk;

   fft_frame_feeder_1024 #(.N(N), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .adc_data   (adc_data),
      .adc_valid  (adc_valid),
      .fft_rdy    (fft_rdy),
      .f_in       (f_in),
      .ipd_i      (ipd_i),
      .idx_i      (idx_i),
      .sof        (sof),
      .eof        (eof),
      .frame_drop (frame_drop),
      .drop_cnt   (drop_cnt)
   );

   typedef struct {int cyc; int cnt;} drop_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;

   // Reference model state
   logic [15:0] exp_q[$];       // expected samples, burst after burst
   int          sof_q[$];       // expected sof cycle per accepted frame, -1 = unchecked
   drop_t       drop_q[$];      // expected drop pulses
   logic [15:0] cur_frame[$];   // samples of the frame being captured
   int          held      = 0;  // frames captured but not yet fully streamed
   int          drops_exp = 0;

   // Stimulus control
   int          sent      = 0;
   int          target    = 0;
   bit          noise     = 1'b1;
   bit          check_lat = 1'b0;
   int          pat       = 0;
   logic [15:0] ramp      = 16'h0;
   bit          alt       = 1'b0;

   // Monitor state
   int          beat      = 0;
   int          low_cnt   = 100;
   int          bursts    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      sof_q.delete();
      drop_q.delete();
      cur_frame.delete();
      held      = 0;
      drops_exp = 0;
   endtask

   // Two buffers: a completed frame is kept while fewer than two frames are
   // waiting or streaming, otherwise it is lost and counted.
   task automatic model_push(input logic [15:0] s);
      cur_frame.push_back(s);
      if (cur_frame.size() == N) begin
         if (held < 2) begin
            foreach (cur_frame[i]) exp_q.push_back(cur_frame[i]);
            held++;
            sof_q.push_back(check_lat ? cyc + 5 : -1);
         end else begin
            drops_exp++;
            drop_q.push_back('{cyc + 1, drops_exp});
         end
         cur_frame.delete();
      end
   endtask

   task automatic next_sample(output logic [15:0] s);
      case (pat)
         0:       begin s = ramp; ramp = ramp + 16'd1; end
         1:       begin s = alt ? 16'hFFFF : 16'h8000; alt = ~alt; end
         default: s = 16'($urandom);
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // ADC driver: one sample every second cycle until the target is reached.
   initial begin
      logic [15:0] v;
      adc_valid = 1'b0;
      adc_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (noise) begin
            adc_valid = 1'($urandom_range(0, 1));
            adc_data  = 16'($urandom);
         end else if (!adc_valid && sent < target) begin
            next_sample(v);
            adc_valid = 1'b1;
            adc_data  = v;
            sent++;
            model_push(v);
         end else begin
            adc_valid = 1'b0;
         end
      end
   end

   // Monitor: compares every output beat and drop pulse against the queues.
   initial begin
      logic [15:0] s;
      drop_t       d;
      int          e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            beat    = 0;
            low_cnt = 100;
         end else begin
            if (frame_drop) begin
               check("drop_expected", drop_q.size() != 0, 1);
               if (drop_q.size() != 0) begin
                  d = drop_q.pop_front();
                  check("drop_cycle", cyc, d.cyc);
                  check("drop_cnt_at_pulse", drop_cnt, d.cnt);
               end
            end
            if (ipd_i) begin
               check("ipd_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  s = exp_q.pop_front();
                  check("f_in", f_in, {s, 16'h0000});
                  check("idx", idx_i, beat);
                  check("sof", sof, beat == 0);
                  check("eof", eof, beat == N - 1);
                  if (beat == 0) begin
                     check("gap_ge2", low_cnt >= 2, 1);
                     if (sof_q.size() != 0) begin
                        e = sof_q.pop_front();
                        if (e >= 0) check("sof_latency", cyc, e);
                     end
                  end
                  beat++;
                  if (beat == N) begin
                     beat = 0;
                     held--;
                     bursts++;
                  end
               end
               low_cnt = 0;
            end else begin
               check("burst_contiguous", beat, 0);
               beat = 0;
               check("sof_eof_idle", {30'h0, sof, eof}, 0);
               low_cnt++;
            end
         end
      end
   end

   task automatic wait_idle(input string name, input int max_cyc);
      int k = 0;
      while ((sent < target || exp_q.size() != 0 || beat != 0 || cur_frame.size() != 0)
             && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check(name, (sent >= target && exp_q.size() == 0 && beat == 0), 1);
      repeat (8) @(negedge clk);
   endtask

   task automatic wait_sent(input string name, input int max_cyc);
      int k = 0;
      while (sent < target && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check(name, sent >= target, 1);
   endtask

   task automatic wait_beat(input string name, input int idx, input int max_cyc);
      int k = 0;
      @(negedge clk);
      while (!(ipd_i && idx_i == AW'(idx)) && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check(name, ipd_i && idx_i == AW'(idx), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #2 model_clear();
      @(negedge clk);
      check("reset_ipd", ipd_i, 0);
      check("reset_drop_cnt", drop_cnt, 0);
      #1 rst = 1'b1;
   endtask

   initial begin
      int b0;

      // 1. Reset with random ADC activity
      repeat (3) @(negedge clk);
      check("rst_f_in", f_in, 0);
      check("rst_ipd", ipd_i, 0);
      check("rst_idx", idx_i, 0);
      check("rst_sof", sof, 0);
      check("rst_eof", eof, 0);
      check("rst_frame_drop", frame_drop, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      noise = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      fft_rdy = 1'b1;
      repeat (40) @(negedge clk);

      // 2. Single ramp frame with latency check
      b0 = bursts;
      check_lat = 1'b1;
      pat = 0; ramp = 16'h0;
      target = sent + N;
      wait_idle("t2_done", 4000);
      check("t2_bursts", bursts, b0 + 1);

      // 3. Negative full-scale data
      b0 = bursts;
      pat = 1; alt = 1'b0;
      target = sent + N;
      wait_idle("t3_done", 4000);
      check("t3_bursts", bursts, b0 + 1);

      // 4. Back-pressure: three frames with the core not ready
      b0 = bursts;
      check_lat = 1'b0;
      @(negedge clk);
      #1 fft_rdy = 1'b0;
      pat = 0; ramp = 16'h0;
      target = sent + 3 * N;
      wait_sent("t4_written", 7000);
      repeat (5) @(negedge clk);
      check("t4_drop_cnt", drop_cnt, 1);
      check("t4_pulse_seen", drop_q.size(), 0);
      check("t4_hold_not_rdy", bursts, b0);
      #1 fft_rdy = 1'b1;
      wait_idle("t4_done", 4000);
      check("t4_bursts", bursts, b0 + 2);

      // 5. Continuous random data, eight frames
      do_reset();
      b0 = bursts;
      check_lat = 1'b1;
      pat = 2;
      target = sent + 8 * N;
      wait_idle("t5_done", 20000);
      check("t5_bursts", bursts, b0 + 8);
      check("t5_drop_cnt", drop_cnt, 0);

      // 6. Ready drop mid-burst, then reset mid-burst
      check_lat = 1'b0;
      pat = 0; ramp = 16'h0;
      target = sent + 16 * N;
      wait_beat("t6_idx500", 500, 4000);
      #1 fft_rdy = 1'b0;
      wait_beat("t6_reach_1023", 1023, 600);
      #1 fft_rdy = 1'b1;
      wait_beat("t6_idx700", 700, 4000);
      #1 rst = 1'b0;
      target = sent;
      @(posedge clk);
      #2 model_clear();
      @(negedge clk);
      check("t6_ipd_after_rst", ipd_i, 0);
      check("t6_drop_cnt", drop_cnt, 0);
      #1 rst = 1'b1;
      b0 = bursts;
      check_lat = 1'b1;
      pat = 0; ramp = 16'h0;
      target = sent + N;
      wait_idle("t6_recover", 4000);
      check("t6_bursts", bursts, b0 + 1);
      check("final_drops_pending", drop_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
